// File: rtl/vt52_pkg.sv
// Shared vt52 core types: TX arbiter states, grant codes, source ids and byte beat payload.
// Used by the keyboard encoder, the response generator and the UART TX arbiter.
package vt52_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned GRANT_W = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN_KBD = 2'b01,
        OWN_RSP = 2'b10
    } arb_state_t;

    localparam logic [GRANT_W-1:0] GRANT_IDLE = 2'b00;
    localparam logic [GRANT_W-1:0] GRANT_KBD  = 2'b01;
    localparam logic [GRANT_W-1:0] GRANT_RSP  = 2'b10;

    typedef enum logic {
        SRC_KBD = 1'b0,
        SRC_RSP = 1'b1
    } src_id_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } tx_beat_t;

    function automatic logic [GRANT_W-1:0] grant_of(arb_state_t st);
        case (st)
            OWN_KBD: grant_of = GRANT_KBD;
            OWN_RSP: grant_of = GRANT_RSP;
            default: grant_of = GRANT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tx_hold_reg.sv
// One-entry valid/ready holding register; a load in the same cycle as a drain keeps valid set.
module tx_hold_reg
    import vt52_pkg::*;
#(
    parameter int unsigned WIDTH = BYTE_W
) (
    input  logic             clk50,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    always_ff @(posedge clk50) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing the console UART transmitter between the
// keyboard encoder and the escape-sequence response generator, with a stalled-owner lock timeout.
module uart_tx_arbiter
    import vt52_pkg::*;
#(
    parameter int unsigned LOCK_TIMEOUT = 1000000
) (
    input  logic               clk50,
    input  logic               reset,
    input  logic [BYTE_W-1:0]  kbd_data,
    input  logic               kbd_valid,
    input  logic               kbd_last,
    output logic               kbd_ready,
    input  logic [BYTE_W-1:0]  rsp_data,
    input  logic               rsp_valid,
    input  logic               rsp_last,
    output logic               rsp_ready,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [GRANT_W-1:0] grant,
    output logic               timeout_evt
);

    localparam int unsigned      CNT_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    arb_state_t       state_q, state_d;
    src_id_t          last_winner_q, last_winner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_d;
    tx_beat_t         beat;
    logic             src_valid;
    logic             hold_free;
    logic             accept;

    // Readys are combinational on tx_ready so back-to-back beats sustain one byte per cycle.
    assign hold_free = !tx_valid || tx_ready;
    assign kbd_ready = (state_q == OWN_KBD) && hold_free && !reset;
    assign rsp_ready = (state_q == OWN_RSP) && hold_free && !reset;
    assign accept    = (kbd_valid && kbd_ready) || (rsp_valid && rsp_ready);

    assign src_valid = (state_q == OWN_KBD) ? kbd_valid :
                       (state_q == OWN_RSP) ? rsp_valid : 1'b0;
    assign beat      = (state_q == OWN_RSP) ? {rsp_last, rsp_data} : {kbd_last, kbd_data};

    tx_hold_reg #(
        .WIDTH (BYTE_W)
    ) u_hold (
        .clk50     (clk50),
        .reset     (reset),
        .load      (accept),
        .load_data (beat.data),
        .drain     (tx_ready),
        .data      (tx_data),
        .valid     (tx_valid)
    );

    // Next-state: arbitration in IDLE, packet tracking and stall timeout while owned.
    always_comb begin
        state_d       = state_q;
        last_winner_d = last_winner_q;
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (kbd_valid && (!rsp_valid || last_winner_q == SRC_RSP)) begin
                    state_d       = OWN_KBD;
                    last_winner_d = SRC_KBD;
                end else if (rsp_valid) begin
                    state_d       = OWN_RSP;
                    last_winner_d = SRC_RSP;
                end
            end
            OWN_KBD, OWN_RSP: begin
                if (accept) begin
                    cnt_d = '0;
                    if (beat.last) begin
                        state_d = IDLE;
                    end
                end else if (!src_valid) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q >= CNT_LAST) begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q       <= IDLE;
            last_winner_q <= SRC_KBD;
            cnt_q         <= '0;
            grant         <= GRANT_IDLE;
            timeout_evt   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_winner_q <= last_winner_d;
            cnt_q         <= cnt_d;
            grant         <= grant_of(state_d);
            timeout_evt   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic
// checked against an acceptance-order scoreboard and protocol invariants.
module tb_uart_tx_arbiter;

    localparam int unsigned LOCK_T   = 16;
    localparam int          SRC_NONE = 2;

    logic       clk50 = 1'b0;
    logic       reset;
    logic [7:0] kbd_data, rsp_data, tx_data;
    logic       kbd_valid, kbd_last, kbd_ready;
    logic       rsp_valid, rsp_last, rsp_ready;
    logic       tx_valid, tx_ready, timeout_evt;
    logic [1:0] grant;

    always #10 clk50 = ~clk50;

    uart_tx_arbiter #(.LOCK_TIMEOUT(LOCK_T)) dut (
        .clk50(clk50), .reset(reset),
        .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_last(kbd_last), .kbd_ready(kbd_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_ready(rsp_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant(grant), .timeout_evt(timeout_evt)
    );

    // Source drivers: per-source queue of {gap[3:0], last, data}
    logic        src_v [2];
    logic        src_l [2];
    logic [7:0]  src_d [2];
    logic [12:0] kq[$];
    logic [12:0] rq[$];
    int          gap_left [2];
    bit          loaded [2];

    assign kbd_valid = src_v[0];
    assign kbd_last  = src_l[0];
    assign kbd_data  = src_d[0];
    assign rsp_valid = src_v[1];
    assign rsp_last  = src_l[1];
    assign rsp_data  = src_d[1];

    // Reference model state
    logic [7:0] exp_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] exp_log[$];
    int         open_src = SRC_NONE;
    bit         prev_hold, prev_acc;
    logic [7:0] prev_data, prev_acc_data;
    bit         rand_mode;

    logic [1:0] s_grant;
    logic [7:0] s_txd;
    logic       s_txv, s_evt, s_kr, s_rr;
    bit         last_kh, last_rh;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int q_size(input int s);
        return (s == 0) ? kq.size() : rq.size();
    endfunction

    function automatic logic [12:0] q_front(input int s);
        return (s == 0) ? kq[0] : rq[0];
    endfunction

    task automatic send(input int s, input logic [7:0] d, input bit l, input int gap);
        logic [12:0] it;
        it = {4'(gap), l, d};
        if (s == 0) kq.push_back(it);
        else        rq.push_back(it);
    endtask

    task automatic drive_src(input int s, input bit hs);
        logic [12:0] it;
        if (hs) begin
            if (s == 0) void'(kq.pop_front());
            else        void'(rq.pop_front());
            loaded[s] = 1'b0;
        end
        if (src_v[s] && !hs) return;
        src_v[s] = 1'b0;
        if (q_size(s) == 0) return;
        it = q_front(s);
        if (!loaded[s]) begin
            gap_left[s] = int'(it[12:9]);
            loaded[s]   = 1'b1;
        end
        if (gap_left[s] == 0) begin
            src_v[s] = 1'b1;
            src_l[s] = it[8];
            src_d[s] = it[7:0];
        end else begin
            gap_left[s]--;
        end
    endtask

    // One clock: sample and check at negedge, then update drivers just after posedge.
    task automatic step();
        bit kh, rh, th;
        int s;
        kh = 1'b0; rh = 1'b0;
        @(negedge clk50);
        s_grant = grant; s_txv = tx_valid; s_txd = tx_data;
        s_evt = timeout_evt; s_kr = kbd_ready; s_rr = rsp_ready;
        if (reset) begin
            exp_q.delete();
            open_src  = SRC_NONE;
            prev_hold = 1'b0;
            prev_acc  = 1'b0;
        end else begin
            kh = kbd_valid && kbd_ready;
            rh = rsp_valid && rsp_ready;
            th = tx_valid && tx_ready;
            chk("grant_legal", 32'(grant != 2'b11), 1);
            chk("kbd_ready_owner", 32'(kbd_ready && grant != 2'b01), 0);
            chk("rsp_ready_owner", 32'(rsp_ready && grant != 2'b10), 0);
            if (grant != 2'b00)
                chk("ready_rule", 32'((grant == 2'b01) ? kbd_ready : rsp_ready), 32'(!tx_valid || tx_ready));
            if (prev_hold) begin
                chk("hold_valid", 32'(tx_valid), 1);
                chk("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (prev_acc) begin
                chk("beat_latency", 32'(tx_valid), 1);
                chk("beat_data", 32'(tx_data), 32'(prev_acc_data));
            end
            if (rand_mode) chk("no_timeout", 32'(timeout_evt), 0);
            if (th) begin
                tx_log.push_back(tx_data);
                chk("tx_pending", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("tx_order", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            chk("one_accept", 32'(kh && rh), 0);
            prev_acc = kh || rh;
            if (kh || rh) begin
                s = rh ? 1 : 0;
                if (open_src != SRC_NONE) chk("atomic_src", 32'(s), 32'(open_src));
                open_src = src_l[s] ? SRC_NONE : s;
                exp_q.push_back(src_d[s]);
                prev_acc_data = src_d[s];
            end
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
        last_kh = kh; last_rh = rh;
        @(posedge clk50);
        #1;
        drive_src(0, kh);
        drive_src(1, rh);
        if (rand_mode) tx_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic run_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((kq.size() != 0 || rq.size() != 0 || src_v[0] || src_v[1] || s_txv || exp_q.size() != 0)
               && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(n < budget), 1);
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_len"}, tx_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < tx_log.size(); i++)
            chk(tag, 32'(tx_log[i]), 32'(exp_log[i]));
        tx_log.delete();
    endtask

    task automatic wait_hs(input string tag, input bit want_rsp);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(want_rsp ? last_rh : last_kh) && n < 20);
        chk(tag, 32'(want_rsp ? last_rh : last_kh), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            src_v[i] = 1'b0; src_l[i] = 1'b0; src_d[i] = 8'h00;
            gap_left[i] = 0; loaded[i] = 1'b0;
        end
        reset = 1'b1; tx_ready = 1'b1; rand_mode = 1'b0;
        repeat (3) @(posedge clk50);
        #1 reset = 1'b0;

        // Reset state
        step();
        chk("rst_grant", 32'(s_grant), 0);
        chk("rst_kbd_ready", 32'(s_kr), 0);
        chk("rst_rsp_ready", 32'(s_rr), 0);
        chk("rst_tx_valid", 32'(s_txv), 0);
        chk("rst_tx_data", 32'(s_txd), 0);
        chk("rst_timeout_evt", 32'(s_evt), 0);

        // Single keyboard byte: arbitration cycle, accept cycle, then output
        send(0, 8'h41, 1'b1, 0);
        step();
        step();
        chk("t1_arb_grant", 32'(s_grant), 0);
        chk("t1_arb_ready", 32'(s_kr), 0);
        step();
        chk("t1_own_grant", 32'(s_grant), 'h1);
        chk("t1_own_ready", 32'(s_kr), 1);
        step();
        chk("t1_tx_valid", 32'(s_txv), 1);
        chk("t1_tx_data", 32'(s_txd), 'h41);
        chk("t1_release_grant", 32'(s_grant), 0);
        step();
        chk("t1_drained", 32'(s_txv), 0);
        exp_log = '{8'h41};
        chk_log("t1_stream");

        // First tie goes to rsp; packet is not interleaved
        send(1, 8'h1B, 1'b0, 0); send(1, 8'h2F, 1'b0, 0); send(1, 8'h4B, 1'b1, 0);
        send(0, 8'h61, 1'b1, 0);
        run_drain("t2_drain", 100);
        exp_log = '{8'h1B, 8'h2F, 8'h4B, 8'h61};
        chk_log("t2_stream");

        // Alternation: last winner kbd -> rsp wins; then last winner rsp -> kbd wins
        send(1, 8'hA0, 1'b1, 0); send(0, 8'hB0, 1'b1, 0);
        run_drain("t3a_drain", 100);
        exp_log = '{8'hA0, 8'hB0};
        chk_log("t3a_stream");
        send(1, 8'hC0, 1'b1, 0);
        run_drain("t3b_drain", 100);
        send(0, 8'hD1, 1'b1, 0); send(1, 8'hD2, 1'b1, 0);
        run_drain("t3c_drain", 100);
        exp_log = '{8'hC0, 8'hD1, 8'hD2};
        chk_log("t3c_stream");

        // Stalled rsp packet: forced release after LOCK_T idle cycles
        send(1, 8'h1B, 1'b0, 0);
        wait_hs("t4_rsp_beat", 1'b1);
        send(0, 8'h55, 1'b1, 0);
        for (int k = 1; k <= int'(LOCK_T); k++) begin
            step();
            chk("t4_hold_grant", 32'(s_grant), 'h2);
            chk("t4_no_evt", 32'(s_evt), 0);
        end
        step();
        chk("t4_evt", 32'(s_evt), 1);
        chk("t4_release_grant", 32'(s_grant), 0);
        open_src = SRC_NONE;
        step();
        chk("t4_evt_pulse", 32'(s_evt), 0);
        chk("t4_kbd_grant", 32'(s_grant), 'h1);
        run_drain("t4_drain", 100);
        exp_log = '{8'h1B, 8'h55};
        chk_log("t4_stream");

        // Serializer stall: no timeout, data held, source back-pressured
        send(1, 8'h71, 1'b0, 0); send(1, 8'h72, 1'b0, 0); send(1, 8'h73, 1'b1, 0);
        wait_hs("t5_rsp_beat", 1'b1);
        tx_ready = 1'b0;
        repeat (100) begin
            step();
            chk("t5_tx_data", 32'(s_txd), 'h71);
            chk("t5_rsp_ready", 32'(s_rr), 0);
            chk("t5_no_evt", 32'(s_evt), 0);
        end
        tx_ready = 1'b1;
        run_drain("t5_drain", 100);
        exp_log = '{8'h71, 8'h72, 8'h73};
        chk_log("t5_stream");

        // Reset mid-packet drops the held byte
        send(0, 8'h11, 1'b0, 0); send(0, 8'h12, 1'b0, 0); send(0, 8'h13, 1'b1, 0);
        wait_hs("t6_kbd_beat", 1'b0);
        step();
        chk("t6_pre_valid", 32'(s_txv), 1);
        reset = 1'b1;
        kq.delete();
        src_v[0] = 1'b0; loaded[0] = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("t6_tx_valid", 32'(s_txv), 0);
        chk("t6_grant", 32'(s_grant), 0);
        chk("t6_kbd_ready", 32'(s_kr), 0);
        chk("t6_rsp_ready", 32'(s_rr), 0);
        tx_log.delete();
        send(0, 8'h21, 1'b1, 0);
        run_drain("t6_drain", 100);
        exp_log = '{8'h21};
        chk_log("t6_stream");

        // Randomized packet traffic with short intra-packet gaps and random back-pressure
        rand_mode = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 40; p++) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++)
                    send(s, 8'($urandom), (b == len - 1), int'($urandom_range(0, 3)));
            end
        end
        run_drain("rand_drain", 5000);
        rand_mode = 1'b0;
        tx_ready  = 1'b1;
        chk("rand_scoreboard_empty", exp_q.size(), 0);
        tx_log.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
